regfile_writeback: RTL and testbench
====================================

Name: regfile_writeback

Overview:
- Write-side controller for the core's register bank.
- Merges single-cycle ALU results and variable-latency load results into the bank's single write port.
- Buffers load results in a small FIFO and drives registered we/wa/wd outputs.
- Keeps a per-register busy scoreboard so the issue stage can stall on pending writes.

Parameters:
DATA_WIDTH, 32, width of write data
REG_ADDR_WIDTH, 5, register address width
REG_DEPTH, 32, number of architectural registers (busy vector width)
FIFO_DEPTH, 4, load-result buffer entries; power of two, >=2

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
alu_valid  input  1  ALU result present this cycle; always accepted
alu_rd  input  REG_ADDR_WIDTH  ALU destination register
alu_data  input  DATA_WIDTH  ALU result
ld_valid  input  1  load result offered
ld_ready  output  1  load result accepted when ld_valid && ld_ready
ld_rd  input  REG_ADDR_WIDTH  load destination register
ld_data  input  DATA_WIDTH  load result
issue_valid  input  1  instruction with destination issued this cycle
issue_rd  input  REG_ADDR_WIDTH  destination of issued instruction
busy  output  REG_DEPTH  bit i = write to register i outstanding
we  output  1  register bank write enable
wa  output  REG_ADDR_WIDTH  register bank write address
wd  output  DATA_WIDTH  register bank write data

Behaviour:
- Reset (rst high at clk edge):
  - we=0, wa=0, wd=0, busy=0, FIFO emptied.
  - ld_ready=0 while rst is high; ld_ready=1 on the first cycle after reset.
- ld_ready is combinational: !rst && (fifo_count < FIFO_DEPTH).
  - Based on current count only. No push when full, even if a pop occurs the same cycle.
- Load acceptance:
  - When ld_valid && ld_ready, push {ld_rd, ld_data} into the FIFO.
  - Entries with ld_rd==0 are accepted but never pushed (discarded).
- Write-port arbitration (one write per cycle, decided each cycle):
  - alu_valid && alu_rd!=0: register the ALU result; next cycle we=1, wa=alu_rd, wd=alu_data.
  - Otherwise, if the FIFO is non-empty: pop the head; next cycle we=1 with the head's rd and data.
  - Otherwise: next cycle we=0. wa/wd hold their previous values.
  - alu_valid with alu_rd==0: no write. The cycle counts as a FIFO drain opportunity.
- Latency:
  - ALU result: 1 cycle (we asserted the cycle after alu_valid).
  - Load result into an empty FIFO with no ALU contention: 2 cycles (push, then pop/register).
  - No bypass from ld input directly to the output.
- FIFO:
  - Circular buffer, read/write pointers wrap modulo FIFO_DEPTH, count 0..FIFO_DEPTH.
  - Simultaneous push and pop is allowed when not full; count is unchanged.
  - A pop from an empty FIFO never occurs.
  - Ordering among load results is preserved.
- Scoreboard:
  - issue_valid && issue_rd!=0 sets busy[issue_rd] at the edge.
  - The cycle we=1 is presented, busy[wa] clears at that edge.
  - Same register set and cleared in the same cycle: set wins.
  - busy[0] is constantly 0.
  - Multiple outstanding writes to one register are not counted. The first commit clears the bit; the issue stage must not issue a second writer while busy.
- Reset mid-operation: all FIFO contents and busy bits are lost; any pending write is cancelled (we=0 the next cycle).
- No combinational path from alu_* or issue_* to any output. ld_ready depends only on state and rst.

Test Plan:
- Reset then idle:
  - rst=1 two cycles, then 0 -> we=0, busy=0, ld_ready=0 during reset, ld_ready=1 the first cycle after.
- ALU write:
  - issue_rd=5 at cycle 0; alu_valid, alu_rd=5, alu_data=0xDEADBEEF at cycle 2 -> busy[5]=1 in cycles 1-3.
  - cycle 3: we=1, wa=5, wd=0xDEADBEEF; busy[5]=0 at cycle 4.
- Contention:
  - Same cycle: ld_valid (rd=7, 0x11) and alu_valid (rd=8, 0x22); alu_valid held 3 more cycles with rd=9 -> writes go to 8, 9, 9, 9 first.
  - The rd=7 write follows on the first cycle after alu_valid drops.
- FIFO full and order:
  - alu_valid held high; push 5 loads (rd=1..5) with ld_valid held -> ld_ready=0 after 4 accepted; rd=5 not accepted.
  - Release alu_valid -> writes rd=1,2,3,4 in order on consecutive cycles, then rd=5 after it is accepted.
- x0 discard:
  - alu_rd=0 and ld_rd=0 with data 0xFFFFFFFF; issue_rd=0 -> we never asserted, busy stays 0.
- Set/clear collision and mid-op reset:
  - issue_rd=3 in the same cycle we=1, wa=3 -> busy[3]=1 afterwards.
  - Then rst with 2 FIFO entries pending -> no further writes, busy=0.

Source files
------------

// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: ALU, load, issue and register-bank signals of the writeback controller
interface regfile_writeback_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_DEPTH      = 32
);
    logic                      alu_valid;
    logic [REG_ADDR_WIDTH-1:0] alu_rd;
    logic [DATA_WIDTH-1:0]     alu_data;
    logic                      ld_valid;
    logic                      ld_ready;
    logic [REG_ADDR_WIDTH-1:0] ld_rd;
    logic [DATA_WIDTH-1:0]     ld_data;
    logic                      issue_valid;
    logic [REG_ADDR_WIDTH-1:0] issue_rd;
    logic [REG_DEPTH-1:0]      busy;
    logic                      we;
    logic [REG_ADDR_WIDTH-1:0] wa;
    logic [DATA_WIDTH-1:0]     wd;

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, issue_valid, issue_rd,
        output ld_ready, busy, we, wa, wd
    );

    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, issue_valid, issue_rd,
        input  ld_ready, busy, we, wa, wd
    );
endinterface

// File: rtl/regfile_writeback.sv
// regfile_writeback: merges ALU and buffered load results into one register write port with a busy scoreboard
module regfile_writeback #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_DEPTH      = 32,
    parameter int FIFO_DEPTH     = 4
) (
    input logic                clk,
    input logic                rst,
    regfile_writeback_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
    localparam logic [REG_DEPTH-1:0] ONE = REG_DEPTH'(1);

    logic [REG_ADDR_WIDTH-1:0] fifo_rd [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]     fifo_data [FIFO_DEPTH];
    logic [PW-1:0]             rptr;
    logic [PW-1:0]             wptr;
    logic [PW:0]               count;
    logic                      alu_win;
    logic                      push;
    logic                      pop;
    logic [REG_DEPTH-1:0]      set_mask;
    logic [REG_DEPTH-1:0]      clr_mask;

    // Fullness is judged on the current count only, so a same-cycle pop never frees a slot early
    assign bus.ld_ready = !rst && (count != FULL);

    // Arbitration: a real ALU write always wins; the FIFO drains on any other cycle
    always_comb begin
        alu_win  = bus.alu_valid && (bus.alu_rd != '0);
        push     = bus.ld_valid && bus.ld_ready && (bus.ld_rd != '0);
        pop      = !alu_win && (count != '0);
        set_mask = (bus.issue_valid && (bus.issue_rd != '0)) ? (ONE << bus.issue_rd) : '0;
        clr_mask = bus.we ? (ONE << bus.wa) : '0;
    end

    // Load buffer storage; contents are don't-care outside the valid window
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wptr]   <= bus.ld_rd;
            fifo_data[wptr] <= bus.ld_data;
        end
    end

    // Circular pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // Registered write port; address and data hold when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.we <= 1'b0;
            bus.wa <= '0;
            bus.wd <= '0;
        end else if (alu_win) begin
            bus.we <= 1'b1;
            bus.wa <= bus.alu_rd;
            bus.wd <= bus.alu_data;
        end else if (pop) begin
            bus.we <= 1'b1;
            bus.wa <= fifo_rd[rptr];
            bus.wd <= fifo_data[rptr];
        end else begin
            bus.we <= 1'b0;
        end
    end

    // Scoreboard: clear on the presented write, set on issue (set wins), x0 never busy
    always_ff @(posedge clk) begin
        if (rst) bus.busy <= '0;
        else bus.busy <= ((bus.busy & ~clr_mask) | set_mask) & ~ONE;
    end
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed stimulus with an expected-write scoreboard for regfile_writeback
module tb_regfile_writeback;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    logic [36:0] exp_q [$];

    regfile_writeback_if bus ();

    regfile_writeback dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic wr_chk(input string tag, input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_we"}, 64'(bus.we), 64'd1);
        chk({tag, "_wa"}, 64'(bus.wa), 64'(a));
        chk({tag, "_wd"}, 64'(bus.wd), 64'(d));
    endtask

    // Every presented write must match the oldest expected write
    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            chk("sb_write_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) chk("sb_write", 64'({bus.wa, bus.wd}), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.ld_valid = 0; bus.ld_rd = 0; bus.ld_data = 0;
        bus.issue_valid = 0; bus.issue_rd = 0;
        tick();
        chk("rst_ld_ready", 64'(bus.ld_ready), 64'd0);
        tick();
        chk("rst_we", 64'(bus.we), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_ld_ready2", 64'(bus.ld_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ld_ready", 64'(bus.ld_ready), 64'd1);
        tick();
        chk("idle_we", 64'(bus.we), 64'd0);

        bus.issue_valid = 1; bus.issue_rd = 5;
        tick();
        bus.issue_valid = 0;
        chk("busy5_c1", 64'(bus.busy[5]), 64'd1);
        tick();
        chk("busy5_c2", 64'(bus.busy[5]), 64'd1);
        bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'hDEADBEEF;
        expect_write(5, 32'hDEADBEEF);
        tick();
        bus.alu_valid = 0;
        wr_chk("alu_c3", 5, 32'hDEADBEEF);
        chk("busy5_c3", 64'(bus.busy[5]), 64'd1);
        tick();
        chk("busy5_c4", 64'(bus.busy[5]), 64'd0);
        chk("alu_c4_we", 64'(bus.we), 64'd0);

        bus.ld_valid = 1; bus.ld_rd = 7; bus.ld_data = 32'h11;
        bus.alu_valid = 1; bus.alu_rd = 8; bus.alu_data = 32'h22;
        expect_write(8, 32'h22);
        tick();
        wr_chk("cont_8", 8, 32'h22);
        bus.ld_valid = 0;
        bus.alu_rd = 9; bus.alu_data = 32'h33;
        for (int i = 0; i < 3; i++) begin
            expect_write(9, 32'h33);
            tick();
            wr_chk("cont_9", 9, 32'h33);
        end
        bus.alu_valid = 0;
        expect_write(7, 32'h11);
        tick();
        wr_chk("cont_7", 7, 32'h11);
        tick();
        chk("cont_idle_we", 64'(bus.we), 64'd0);

        bus.alu_valid = 1; bus.alu_rd = 10; bus.alu_data = 32'hA0;
        bus.ld_valid = 1;
        for (int i = 1; i <= 4; i++) begin
            bus.ld_rd = 5'(i); bus.ld_data = 32'h100 + 32'(i);
            chk("full_ld_ready_open", 64'(bus.ld_ready), 64'd1);
            expect_write(10, 32'hA0);
            tick();
        end
        bus.ld_rd = 5; bus.ld_data = 32'h105;
        for (int i = 0; i < 2; i++) begin
            chk("full_ld_ready_closed", 64'(bus.ld_ready), 64'd0);
            expect_write(10, 32'hA0);
            tick();
        end
        chk("full_ld_ready_closed2", 64'(bus.ld_ready), 64'd0);
        bus.alu_valid = 0;
        for (int i = 1; i <= 5; i++) expect_write(5'(i), 32'h100 + 32'(i));
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 2) bus.ld_valid = 0;
            wr_chk("fifo_order", 5'(i), 32'h100 + 32'(i));
        end
        tick();
        chk("fifo_drained_we", 64'(bus.we), 64'd0);

        bus.alu_valid = 1; bus.alu_rd = 0; bus.alu_data = 32'hFFFFFFFF;
        bus.ld_valid = 1; bus.ld_rd = 0; bus.ld_data = 32'hFFFFFFFF;
        bus.issue_valid = 1; bus.issue_rd = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("x0_we", 64'(bus.we), 64'd0);
            chk("x0_busy", 64'(bus.busy), 64'd0);
        end
        bus.alu_valid = 0; bus.ld_valid = 0; bus.issue_valid = 0;
        tick();
        tick();
        chk("x0_after_we", 64'(bus.we), 64'd0);

        bus.issue_valid = 1; bus.issue_rd = 3;
        tick();
        bus.issue_valid = 0;
        bus.alu_valid = 1; bus.alu_rd = 3; bus.alu_data = 32'h333;
        expect_write(3, 32'h333);
        tick();
        wr_chk("coll_wr", 3, 32'h333);
        bus.alu_valid = 0;
        bus.issue_valid = 1; bus.issue_rd = 3;
        tick();
        bus.issue_valid = 0;
        chk("coll_set_wins", 64'(bus.busy[3]), 64'd1);
        tick();
        chk("coll_busy_hold", 64'(bus.busy[3]), 64'd1);

        bus.alu_valid = 1; bus.alu_rd = 11; bus.alu_data = 32'hB;
        bus.ld_valid = 1; bus.ld_rd = 12; bus.ld_data = 32'hC;
        bus.issue_valid = 1; bus.issue_rd = 20;
        expect_write(11, 32'hB);
        tick();
        bus.issue_valid = 0;
        bus.ld_rd = 13; bus.ld_data = 32'hD;
        expect_write(11, 32'hB);
        tick();
        chk("midrst_busy20", 64'(bus.busy[20]), 64'd1);
        bus.ld_valid = 0; bus.alu_valid = 0;
        rst = 1'b1;
        tick();
        chk("midrst_we", 64'(bus.we), 64'd0);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst_no_write", 64'(bus.we), 64'd0);
            chk("midrst_busy_clear", 64'(bus.busy), 64'd0);
        end
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
